// File: rtl/alu_pipe_mc.sv
// alu_pipe_mc: execute-stage ALU with a registered result and valid/ready on both sides.
// Single-cycle ops (add/sub/logic/shifts/compares) complete one cycle after accept.
// Unsigned MUL/MULHU (shift-add) and DIVU/REMU (restoring) iterate one bit per cycle
// and complete XLEN+1 cycles after accept. Divide by zero completes in one cycle.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid, in_ready      operation handshake (ctrl/data1/data2 captured at accept)
//   ctrl, data1, data2      opcode and operands
//   out_valid, out_ready    result handshake
//   write_data, zero        result and result==0 flag
//   illegal                 opcode was 0 or 15
//   busy                    multi-cycle op in progress
module alu_pipe_mc #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] write_data,
  output logic            zero,
  output logic            illegal,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [3:0] OpAdd   = 4'd1;
  localparam logic [3:0] OpSub   = 4'd2;
  localparam logic [3:0] OpAnd   = 4'd3;
  localparam logic [3:0] OpOr    = 4'd4;
  localparam logic [3:0] OpSrl   = 4'd5;
  localparam logic [3:0] OpSll   = 4'd6;
  localparam logic [3:0] OpXor   = 4'd7;
  localparam logic [3:0] OpSra   = 4'd8;
  localparam logic [3:0] OpSlt   = 4'd9;
  localparam logic [3:0] OpSltu  = 4'd10;
  localparam logic [3:0] OpMul   = 4'd11;
  localparam logic [3:0] OpMulhu = 4'd12;
  localparam logic [3:0] OpDivu  = 4'd13;
  localparam logic [3:0] OpRemu  = 4'd14;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       opa_q, opa_d;
  logic [XLEN-1:0]       opb_q, opb_d;
  logic                  sel_hi_q, sel_hi_d;

  logic                  out_valid_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  zero_q;
  logic                  illegal_q;

  logic                  accept;
  logic                  is_mul;
  logic                  is_div;
  logic [SHW-1:0]        shamt;
  logic [XLEN-1:0]       alu_res;
  logic                  alu_ill;

  logic [XLEN-1:0]       mul_addend;
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_acc_nxt;
  logic [XLEN:0]         div_shift;
  logic [XLEN:0]         div_sub;
  logic                  div_ge;
  logic [2*XLEN-1:0]     div_acc_nxt;

  logic                  done;
  logic [XLEN-1:0]       done_res;
  logic                  done_ill;

  assign in_ready   = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q != StIdle);
  assign out_valid  = out_valid_q;
  assign write_data = wdata_q;
  assign zero       = zero_q;
  assign illegal    = illegal_q;

  assign shamt  = data2[SHW-1:0];
  assign is_mul = (ctrl == OpMul) || (ctrl == OpMulhu);
  // Divide by zero never enters the iterative path; it resolves as a single-cycle op.
  assign is_div = ((ctrl == OpDivu) || (ctrl == OpRemu)) && (data2 != '0);

  // Single-cycle result, also covering divide-by-zero and illegal opcodes.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ctrl)
      OpAdd:   alu_res = data1 + data2;
      OpSub:   alu_res = data1 - data2;
      OpAnd:   alu_res = data1 & data2;
      OpOr:    alu_res = data1 | data2;
      OpSrl:   alu_res = data1 >> shamt;
      OpSll:   alu_res = data1 << shamt;
      OpXor:   alu_res = data1 ^ data2;
      OpSra:   alu_res = $unsigned($signed(data1) >>> shamt);
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, (data1 < data2)};
      OpMul,
      OpMulhu: alu_res = '0;
      OpDivu:  alu_res = '1;
      OpRemu:  alu_res = data1;
      default: alu_ill = 1'b1;
    endcase
  end

  // Shift-add multiply: upper half accumulates, the whole accumulator shifts right so
  // the finished low product bits fall into the lower half.
  always_comb begin
    mul_addend  = opb_q[0] ? opa_q : '0;
    mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    mul_acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
  end

  // Restoring divide: acc holds {remainder, dividend/quotient}; quotient bits enter at
  // the bottom as dividend bits leave at the top.
  always_comb begin
    div_shift   = acc_q[2*XLEN-1:XLEN-1];
    div_sub     = div_shift - {1'b0, opb_q};
    div_ge      = (div_shift >= {1'b0, opb_q});
    div_acc_nxt = {(div_ge ? div_sub[XLEN-1:0] : div_shift[XLEN-1:0]),
                   acc_q[XLEN-2:0], div_ge};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sel_hi_d = sel_hi_q;
    done     = 1'b0;
    done_res = '0;
    done_ill = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = StMul;
            cnt_d    = CW'(XLEN);
            acc_d    = '0;
            opa_d    = data1;
            opb_d    = data2;
            sel_hi_d = (ctrl == OpMulhu);
          end else if (is_div) begin
            state_d  = StDiv;
            cnt_d    = CW'(XLEN);
            acc_d    = {{XLEN{1'b0}}, data1};
            opa_d    = data1;
            opb_d    = data2;
            sel_hi_d = (ctrl == OpRemu);
          end else begin
            done     = 1'b1;
            done_res = alu_res;
            done_ill = alu_ill;
          end
        end
      end
      StMul: begin
        acc_d = mul_acc_nxt;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = StIdle;
          done     = 1'b1;
          done_res = sel_hi_q ? mul_acc_nxt[2*XLEN-1:XLEN] : mul_acc_nxt[XLEN-1:0];
        end
      end
      StDiv: begin
        acc_d = div_acc_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d  = StIdle;
          done     = 1'b1;
          done_res = sel_hi_q ? div_acc_nxt[2*XLEN-1:XLEN] : div_acc_nxt[XLEN-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sel_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sel_hi_q <= sel_hi_d;
    end
  end

  // A completing op wins over consumption so back-to-back results have no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      wdata_q     <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (done) begin
      out_valid_q <= 1'b1;
      wdata_q     <= done_res;
      zero_q      <= (done_res == '0);
      illegal_q   <= done_ill;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe_mc.sv
module tb_alu_pipe_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] write_data;
  logic        zero;
  logic        illegal;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_pipe_mc #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ctrl       (ctrl),
    .data1      (data1),
    .data2      (data2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .write_data (write_data),
    .zero       (zero),
    .illegal    (illegal),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the opcode table: result, illegal flag, latency.
  task automatic model_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] p;
    logic [31:0] mask;
    int          s;
    s    = int'(b[4:0]);
    p    = {32'b0, a} * {32'b0, b};
    mask = 32'hFFFF_FFFF >> s;
    r    = 32'h0;
    ill  = 1'b0;
    lat  = 1;
    case (c)
      4'd1:  r = a + b;
      4'd2:  r = a - b;
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a >> s;
      4'd6:  r = a << s;
      4'd7:  r = a ^ b;
      4'd8:  r = (a >> s) | (a[31] ? ~mask : 32'h0);
      4'd9:  r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      4'd11: begin r = p[31:0];  lat = 33; end
      4'd12: begin r = p[63:32]; lat = 33; end
      4'd13: if (b == 0) r = 32'hFFFF_FFFF; else begin r = a / b; lat = 33; end
      4'd14: if (b == 0) r = a;             else begin r = a % b; lat = 33; end
      default: ill = 1'b1;
    endcase
  endtask

  // Cycle model: pending countdown for an in-flight op plus the held output.
  logic        m_init = 1'b0;
  logic        m_ov   = 1'b0;
  logic [31:0] m_wd   = '0;
  logic        m_ill  = 1'b0;
  int          m_pend = 0;
  logic [31:0] m_pres = '0;

  always @(negedge clk) begin
    logic        exp_ir;
    logic        done;
    logic [31:0] r;
    logic        ill;
    int          lat;
    exp_ir = (m_pend == 0) && (!m_ov || out_ready);
    if (m_init) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
      chk("busy", {31'b0, busy}, {31'b0, (m_pend != 0)});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      if (m_ov) begin
        chk("write_data", write_data, m_wd);
        chk("zero", {31'b0, zero}, {31'b0, (m_wd == 0)});
        chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
      end
    end
    // Advance the model to the upcoming rising edge.
    if (!rst_n) begin
      m_init = 1'b1;
      m_ov   = 1'b0;
      m_wd   = '0;
      m_ill  = 1'b0;
      m_pend = 0;
    end else if (m_init) begin
      done = 1'b0;
      r    = '0;
      ill  = 1'b0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          done = 1'b1;
          r    = m_pres;
        end
      end
      if (in_valid && exp_ir) begin
        model_calc(ctrl, data1, data2, r, ill, lat);
        if (lat == 1) done = 1'b1;
        else begin
          m_pend = lat - 1;
          m_pres = r;
        end
      end
      if (done) begin
        m_ov  = 1'b1;
        m_wd  = r;
        m_ill = ill;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Issue one op, wait for accept, then measure cycles until out_valid.
  task automatic do_op(input string name, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic exp_ill,
                       input int exp_lat);
    int  lat;
    logic got;
    @(posedge clk); #1;
    in_valid = 1'b1; ctrl = c; data1 = a; data2 = b;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; ctrl = 4'hx; data1 = 'x; data2 = 'x;
    lat = 0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) begin got = 1'b1; break; end
      if (exp_lat > 1) chk({name, "_busy_wait"}, {31'b0, busy}, 32'd1);
    end
    if (!got) chk({name, "_result_timeout"}, 32'd0, 32'd1);
    chk({name, "_data"}, write_data, exp);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
    chk({name, "_zero"}, {31'b0, zero}, {31'b0, (exp == 0)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ctrl = '0; data1 = '0; data2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_write_data", write_data, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD then SUB back-to-back, no bubble.
    @(posedge clk); #1;
    in_valid = 1'b1; ctrl = 4'd1; data1 = 32'd7; data2 = 32'd5;
    @(posedge clk); #1;
    ctrl = 4'd2; data1 = 32'd5; data2 = 32'd5;
    @(negedge clk);
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_data", write_data, 32'd12);
    chk("add_zero", {31'b0, zero}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("sub_valid", {31'b0, out_valid}, 32'd1);
    chk("sub_data", write_data, 32'd0);
    chk("sub_zero", {31'b0, zero}, 32'd1);

    do_op("sra",   4'd8,  32'h8000_0000, 32'd36, 32'hF800_0000, 1'b0, 1);
    do_op("srl",   4'd5,  32'h8000_0000, 32'd36, 32'h0800_0000, 1'b0, 1);
    do_op("slt",   4'd9,  32'hFFFF_FFFF, 32'd1,  32'd1, 1'b0, 1);
    do_op("sltu",  4'd10, 32'hFFFF_FFFF, 32'd1,  32'd0, 1'b0, 1);
    do_op("slt2",  4'd9,  32'd1, 32'hFFFF_FFFF,  32'd0, 1'b0, 1);
    do_op("sll",   4'd6,  32'd1, 32'd33,         32'd2, 1'b0, 1);
    do_op("xor",   4'd7,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1);
    do_op("and",   4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
    do_op("or",    4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1);
    do_op("sub_wrap", 4'd2, 32'd0, 32'd1,        32'hFFFF_FFFF, 1'b0, 1);
    do_op("mul",   4'd11, 32'hFFFF_FFFF, 32'd2,  32'hFFFF_FFFE, 1'b0, 33);
    do_op("mulhu", 4'd12, 32'hFFFF_FFFF, 32'd2,  32'd1, 1'b0, 33);
    do_op("mul_max",   4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 33);
    do_op("mulhu_max", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    do_op("divu",  4'd13, 32'd100, 32'd7,        32'd14, 1'b0, 33);
    do_op("remu",  4'd14, 32'd100, 32'd7,        32'd2, 1'b0, 33);
    do_op("divu_big", 4'd13, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 1'b0, 33);
    do_op("remu_big", 4'd14, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 33);
    do_op("remu_small", 4'd14, 32'd7, 32'd100,   32'd7, 1'b0, 33);
    do_op("divu0", 4'd13, 32'd100, 32'd0,        32'hFFFF_FFFF, 1'b0, 1);
    do_op("remu0", 4'd14, 32'd100, 32'd0,        32'd100, 1'b0, 1);
    do_op("ill0",  4'd0,  32'd5, 32'd6,          32'd0, 1'b1, 1);

    // Backpressure: hold the ADD 1+1 result, with a second op waiting.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; ctrl = 4'd1; data1 = 32'd1; data2 = 32'd1;
    @(posedge clk); #1;
    ctrl = 4'd1; data1 = 32'd2; data2 = 32'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_data", write_data, 32'd2);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      if (k < 4) @(posedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_next_data", write_data, 32'd5);

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    in_valid = 1'b1; ctrl = 4'd11; data1 = 32'hFFFF_FFFF; data2 = 32'd2;
    @(negedge clk);
    chk("mid_mul_accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_mul_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    do_op("post_rst_add", 4'd1,  32'd3, 32'd4, 32'd7, 1'b0, 1);
    do_op("ill15",        4'd15, 32'd3, 32'd4, 32'd0, 1'b1, 1);

    // Nothing from the discarded multiply may surface later.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k > 0) chk("no_stray_result", {31'b0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe_mc.md
Name: alu_pipe_mc

Overview:
Parametrised successor to the single-cycle execute ALU. It has a registered output, a valid/ready handshake on both sides, and a wider op set including SRA, XOR and compares. It also adds iterative multi-cycle unsigned multiply and divide. It sits in the execute stage between the operand-forward mux and the writeback register, and can stall the front end through in_ready.

Parameters:
XLEN, 32, datapath width. Must be a power of two and ≥ 8.
SHW, $clog2(XLEN), localparam. Shift-amount width. Not overridable.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  operation offered
in_ready  out  1  block accepts an operation this cycle
ctrl  in  4  opcode, see Behaviour
data1  in  XLEN  operand A
data2  in  XLEN  operand B
out_valid  out  1  result held on outputs
out_ready  in  1  consumer takes the result this cycle
write_data  out  XLEN  result
zero  out  1  write_data == 0
illegal  out  1  ctrl was 0 or 15
busy  out  1  multi-cycle op in progress

Behaviour:
- Opcodes:
  - 1 ADD: A+B, mod 2^XLEN.
  - 2 SUB: A−B.
  - 3 AND.
  - 4 OR.
  - 5 SRL: A >> B[SHW-1:0].
  - 6 SLL: A << B[SHW-1:0].
  - 7 XOR.
  - 8 SRA: arithmetic A >> B[SHW-1:0].
  - 9 SLT: signed A<B → 1, else 0.
  - 10 SLTU: unsigned A<B → 1, else 0.
  - 11 MUL: low XLEN bits of A*B, unsigned.
  - 12 MULHU: high XLEN bits of A*B, unsigned.
  - 13 DIVU: A/B, unsigned.
  - 14 REMU: A%B, unsigned.
  - 0 and 15: write_data=0, illegal=1, latency 1.
- Shifts use only the low SHW bits of B; upper bits are ignored.
- Accept: an op is accepted on a cycle with in_valid && in_ready. Operands and ctrl are captured at accept; the inputs are don't-care afterwards.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back single-cycle ops therefore sustain 1 op/cycle.
- State machine: IDLE, MUL, DIV.
  - IDLE, accept of ops 1–10/0/15: result registered. out_valid=1 on the next edge.
  - IDLE, accept of 11/12: go to MUL. Iteration counter = XLEN. 2·XLEN accumulator cleared. One shift-add step per cycle, LSB-first over B.
  - MUL: counter decrements each cycle. When counter hits 0, load the low or high half into write_data, set out_valid=1, return to IDLE. Latency from accept edge to out_valid is exactly XLEN+1 cycles.
  - IDLE, accept of 13/14 with B≠0: go to DIV. Restoring division, one quotient bit per cycle, MSB-first, XLEN iterations. Same XLEN+1 latency.
  - IDLE, accept of 13/14 with B==0: no DIV state. Latency 1. DIVU result = all ones; REMU result = A.
- busy = (state≠IDLE).
- Output hold:
  - write_data, zero, illegal and out_valid stay stable while out_valid && !out_ready.
  - out_valid clears on the edge where out_ready=1, unless a new op completes on that same edge. In that case out_valid stays 1 and the outputs take the new result.
- zero and illegal are registered together with write_data and are meaningful only while out_valid=1.
- Simultaneous events: a single-cycle op accepted in the same cycle the previous result is consumed produces a new result on the next edge with no bubble.
- Reset: while rst_n=0 on a clock edge, the following hold, including mid-MUL/DIV:
  - state=IDLE, counter=0, accumulators=0.
  - out_valid=0, write_data=0, zero=0, illegal=0, busy=0.
  - in_ready may be 1 on the first cycle after reset release. An in-flight op is discarded with no output.
- Multi-cycle ops accept no new op until their result is produced and consumed.

Test Plan:
- ADD 7+5, out_ready=1: write_data=12, zero=0, out_valid one cycle after accept. SUB 5−5 next cycle: write_data=0, zero=1, no bubble between results.
- SRA A=0x80000000, B=36 (shift 4): 0xF8000000. SRL same operands: 0x08000000. SLT A=0xFFFFFFFF, B=1: 1. SLTU same operands: 0.
- MUL A=0xFFFFFFFF, B=2: write_data=0xFFFFFFFE, out_valid exactly 33 cycles after accept, busy=1 and in_ready=0 throughout. MULHU same operands: write_data=1.
- DIVU 100/7: 14. REMU 100/7: 2, both at latency 33. DIVU 100/0: 0xFFFFFFFF at latency 1. REMU 100/0: 100 at latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 1+1. write_data stays 2, out_valid stays 1, in_ready stays 0. A pending in_valid op is accepted in the cycle out_ready rises.
- Reset mid-MUL (cycle 10 of 32): after the reset edge, out_valid=0, busy=0, state IDLE, write_data=0. A subsequent ADD 3+4 yields 7. ctrl=15 yields illegal=1, write_data=0.
